keypad_scan: RTL
================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 The module SHALL have parameter SCAN_DIV, default 13500, meaning clocks per column step (250 us at 54 MHz).
REQ-002 The module SHALL have parameter DEB_CNT, default 540000, meaning clocks a row pattern must stay stable to count as a press or release (10 ms).
REQ-003 The module SHALL have parameter REPEAT_CNT, default 27000000, meaning clocks between auto-repeat pulses (0.5 s); it is used only with KEYPAD_REPEAT_EN.
REQ-004 The module SHALL have port clk, input, 1 bit: the single system clock, 54 MHz.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous active-low reset.
REQ-006 The module SHALL have port row, input, 4 bits: keypad rows, active-low, externally pulled up and asynchronous to clk.
REQ-007 The module SHALL have port col, output, 4 bits: keypad column drive, active-low, one-hot-zero.
REQ-008 The module SHALL have port enable, output, 1 bit: one-cycle key-event pulse to the display stage.
REQ-009 The module SHALL have port temp_num, output, 8 bits: 7-segment pattern of the last key, {dp,g,f,e,d,c,b,a}, where 1 means the segment is lit.
REQ-010 The module SHALL have port key_code, output, 4 bits: hex value of the last key.

Function
REQ-011 The row input SHALL pass through a 2-FF synchronizer before any use; all timing in this document counts from the synchronized value.
REQ-012 The state machine SHALL have four states: SCAN, PRESS_DEB, HELD and REL_DEB.
REQ-013 In SCAN, col SHALL step 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing every SCAN_DIV clocks; any synchronized row bit at 0 SHALL freeze col and move the block to PRESS_DEB.
REQ-014 In PRESS_DEB, col SHALL be held, and a debounce counter SHALL count while the row pattern equals the captured pattern.
REQ-015 In PRESS_DEB, a changed pattern SHALL return the block to SCAN with the column scan continuing, and no event SHALL be produced.
REQ-016 When the PRESS_DEB counter reaches DEB_CNT-1, the block SHALL enter HELD, update key_code and temp_num, and assert enable for exactly that cycle.
REQ-017 Key mapping SHALL be, by rows r0..r3 and columns c0..c3: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D.
REQ-018 If several rows are low, the lowest-index row SHALL win.
REQ-019 The segment table SHALL be 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71, with dp always 0.
REQ-020 In HELD, all rows returning high SHALL move the block to REL_DEB.
REQ-021 In REL_DEB, rows staying high for DEB_CNT clocks SHALL return the block to SCAN with col advanced one column; any low row SHALL return it to HELD.
REQ-022 key_code and temp_num SHALL change only in the cycle enable is high, and SHALL stay stable otherwise.
REQ-023 enable SHALL be followed by at least 4 low cycles before it can be high again, as the display stage requires.
REQ-024 A second key pressed while another is held SHALL be ignored until a full release.
REQ-025 All counters SHALL saturate or clear and never wrap into a false event.

Reset
REQ-026 While reset=0, the outputs SHALL be col=1110, enable=0, temp_num=00 and key_code=0, the state SHALL be SCAN, and all counters and synchronizer flops SHALL be 0 (row synchronizer flops 1).
REQ-027 Asserting reset mid-debounce or mid-hold SHALL abort immediately with no enable pulse, and the block SHALL restart scanning from c0 on release.

Configuration
REQ-028 With macro KEYPAD_REPEAT_EN defined, HELD SHALL re-assert enable for one cycle every REPEAT_CNT clocks with the same key_code and temp_num; the repeat counter SHALL clear on entry to HELD.
REQ-029 Without KEYPAD_REPEAT_EN, exactly one enable SHALL be produced per debounced press, and the repeat counter logic SHALL not be present.

Verification (DEB_CNT=8, SCAN_DIV=4, REPEAT_CNT=32 for sim)
REQ-030 Press r1 while col=1101, clean -> one enable pulse after sync plus 8 clocks, key_code=5, temp_num=6D.
REQ-031 Bounce r0 low for 3 clocks, then high -> no enable, scan resumes, col keeps rotating.
REQ-032 Hold r2 and r3 low while col=1110 -> key_code=7, temp_num=07, single pulse.
REQ-033 Hold a key for 100 clocks -> without the macro, 1 pulse; with KEYPAD_REPEAT_EN, pulses at entry plus 32 and plus 64 (3 total).
REQ-034 Assert reset 4 clocks into PRESS_DEB -> no pulse, all outputs at reset values, col=1110 after release.
REQ-035 Release with 2-clock glitch low during REL_DEB -> no new pulse, and the block returns to HELD.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column scan, press/release debounce, hex key code and 7-segment output.
// Define KEYPAD_REPEAT_EN to emit an auto-repeat enable pulse every REPEAT_CNT clocks while a key is held.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// SCAN      | stepping the active-low column every SCAN_DIV clocks
// PRESS_DEB | column frozen, waiting for the captured row pattern to stay put
// HELD      | key accepted, waiting for every row to go high
// REL_DEB   | all rows high, waiting DEB_CNT clocks before resuming the scan

module keypad_scan #(
  parameter int SCAN_DIV   = 13500,
  parameter int DEB_CNT    = 540000,
  parameter int REPEAT_CNT = 27000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       enable,
  output logic [7:0] temp_num,
  output logic [3:0] key_code
);

  localparam logic [1:0] ST_SCAN      = 2'd0;
  localparam logic [1:0] ST_PRESS_DEB = 2'd1;
  localparam logic [1:0] ST_HELD      = 2'd2;
  localparam logic [1:0] ST_REL_DEB   = 2'd3;

  localparam int SCAN_W = $clog2(SCAN_DIV + 1);
  localparam int DEB_W  = $clog2(DEB_CNT + 1);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CNT - 1);

  // The display stage needs >= 4 idle cycles between events; these minimums guarantee that.
  if (SCAN_DIV < 1 || DEB_CNT < 4 || REPEAT_CNT < 5) begin : g_bad_params
    $error("keypad_scan: SCAN_DIV, DEB_CNT or REPEAT_CNT too small");
  end

  logic [1:0]        state;
  logic [3:0]        row_meta;
  logic [3:0]        row_sync;
  logic [3:0]        cap_row;
  logic [SCAN_W-1:0] scan_cnt;
  logic [DEB_W-1:0]  deb_cnt;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CNT + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CNT - 1);
  logic [REP_W-1:0] rep_cnt;
`endif

  function automatic logic [3:0] key_lookup(input logic [3:0] rows, input logic [3:0] cols);
    logic [1:0] r;
    logic [1:0] c;
    logic [3:0] k;
    // lowest-index active row wins when several are low
    if (!rows[0])      r = 2'd0;
    else if (!rows[1]) r = 2'd1;
    else if (!rows[2]) r = 2'd2;
    else               r = 2'd3;
    if (!cols[0])      c = 2'd0;
    else if (!cols[1]) c = 2'd1;
    else if (!cols[2]) c = 2'd2;
    else               c = 2'd3;
    case ({r, c})
      4'b00_00: k = 4'h1;
      4'b00_01: k = 4'h2;
      4'b00_10: k = 4'h3;
      4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;
      4'b01_01: k = 4'h5;
      4'b01_10: k = 4'h6;
      4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;
      4'b10_01: k = 4'h8;
      4'b10_10: k = 4'h9;
      4'b10_11: k = 4'hC;
      4'b11_00: k = 4'hE;
      4'b11_01: k = 4'h0;
      4'b11_10: k = 4'hF;
      default:  k = 4'hD;
    endcase
    return k;
  endfunction

  function automatic logic [7:0] seg_lookup(input logic [3:0] k);
    logic [7:0] s;
    case (k)
      4'h0:    s = 8'h3F;
      4'h1:    s = 8'h06;
      4'h2:    s = 8'h5B;
      4'h3:    s = 8'h4F;
      4'h4:    s = 8'h66;
      4'h5:    s = 8'h6D;
      4'h6:    s = 8'h7D;
      4'h7:    s = 8'h07;
      4'h8:    s = 8'h7F;
      4'h9:    s = 8'h6F;
      4'hA:    s = 8'h77;
      4'hB:    s = 8'h7C;
      4'hC:    s = 8'h39;
      4'hD:    s = 8'h5E;
      4'hE:    s = 8'h79;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_SCAN;
      col      <= 4'b1110;
      cap_row  <= 4'hF;
      scan_cnt <= '0;
      deb_cnt  <= '0;
      enable   <= 1'b0;
      key_code <= 4'h0;
      temp_num <= 8'h00;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt  <= '0;
`endif
    end else begin
      enable <= 1'b0;
      case (state)
        ST_SCAN: begin
          if (row_sync != 4'hF) begin
            cap_row <= row_sync;
            deb_cnt <= '0;
            state   <= ST_PRESS_DEB;
          end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            col      <= {col[2:0], col[3]};
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        ST_PRESS_DEB: begin
          // scan_cnt is left untouched so an aborted press resumes the scan where it paused
          if (row_sync != cap_row) begin
            state <= ST_SCAN;
          end else if (deb_cnt == DEB_LAST) begin
            state    <= ST_HELD;
            enable   <= 1'b1;
            key_code <= key_lookup(cap_row, col);
            temp_num <= seg_lookup(key_lookup(cap_row, col));
`ifdef KEYPAD_REPEAT_EN
            rep_cnt  <= '0;
`endif
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        ST_HELD: begin
          if (row_sync == 4'hF) begin
            deb_cnt <= '0;
            state   <= ST_REL_DEB;
          end
`ifdef KEYPAD_REPEAT_EN
          else if (rep_cnt == REP_LAST) begin
            rep_cnt <= '0;
            enable  <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
`endif
        end
        ST_REL_DEB: begin
          if (row_sync != 4'hF) begin
            state <= ST_HELD;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt <= '0;
`endif
          end else if (deb_cnt == DEB_LAST) begin
            state    <= ST_SCAN;
            scan_cnt <= '0;
            col      <= {col[2:0], col[3]};
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: state <= ST_SCAN;
      endcase
    end
  end

endmodule
